// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its read ports.
// The optional same-cycle commit bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = $clog2(REG_NUM);
    localparam int ROB_SIZE  = 16;
    localparam int ROB_W     = $clog2(ROB_SIZE);

    typedef logic [REG_NUM-1:0][XLEN-1:0]  reg_vals_t;
    typedef logic [REG_NUM-1:0][ROB_W-1:0] reg_tags_t;

    // x0 is hardwired, so any request naming it is a no-op.
    function automatic logic targets_reg(input logic en, input logic [REG_IDX_W-1:0] rd);
        return en && (rd != '0);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: returns ready flag, pending ROB tag and value for idx.
// With REGFILE_BYPASS_EN, a matching commit in the same cycle is forwarded.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  reg_vals_t            values,
    input  logic [REG_NUM-1:0]   busy,
    input  reg_tags_t            tags,
    input  logic                 is_commit,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_W-1:0]     commit_rob_id,
    input  logic [XLEN-1:0]      commit_value,
    output logic                 iq,
    output logic [ROB_W-1:0]     q,
    output logic [XLEN-1:0]      v
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        iq = 1'b1;
        q  = '0;
        v  = '0;
        if (idx != '0) begin
            iq = !busy[idx];
            q  = tags[idx];
            v  = values[idx];
`ifdef REGFILE_BYPASS_EN
            // Only the commit that retires the outstanding producer may forward.
            if (is_commit && (commit_rd == idx) && busy[idx] && (tags[idx] == commit_rob_id)) begin
                iq = 1'b1;
                v  = commit_value;
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{is_commit, commit_rd, commit_rob_id, commit_value};
`endif

endmodule

// File: rtl/regfile.sv
// Architectural register file with rename tags (busy/ROB id) for a Tomasulo-style core.
// Define REGFILE_BYPASS_EN to forward a retiring commit to the read ports in the same cycle.
module regfile
    import regfile_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rob_clear,
    input  logic                 is_issue,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_W-1:0]     issue_rob_id,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 iQ1,
    output logic                 iQ2,
    output logic [ROB_W-1:0]     Q1,
    output logic [ROB_W-1:0]     Q2,
    output logic [XLEN-1:0]      V1,
    output logic [XLEN-1:0]      V2,
    input  logic                 is_commit,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_W-1:0]     commit_rob_id,
    input  logic [XLEN-1:0]      commit_value
);

    reg_vals_t          values;
    logic [REG_NUM-1:0] busy;
    reg_tags_t          tags;

    logic issue_hit;
    logic commit_hit;

    assign issue_hit  = targets_reg(is_issue, issue_rd);
    assign commit_hit = targets_reg(is_commit, commit_rd);

    // NOTE: sequential state uses non-blocking assignments; the later assignment
    // in program order wins, which gives clear > issue > commit-release on busy.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            values <= '0;
            busy   <= '0;
        end else if (rdy_in) begin
            if (commit_hit) begin
                values[commit_rd] <= commit_value;
                if (busy[commit_rd] && (tags[commit_rd] == commit_rob_id))
                    busy[commit_rd] <= 1'b0;
            end
            if (rob_clear)
                busy <= '0;
            else if (issue_hit)
                busy[issue_rd] <= 1'b1;
        end
    end

    // NOTE: tags are only meaningful while busy is set, so the tag storage has no reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !rob_clear && issue_hit)
            tags[issue_rd] <= issue_rob_id;
    end

    regfile_read_port u_read_port1 (
        .idx           (rs1),
        .values        (values),
        .busy          (busy),
        .tags          (tags),
        .is_commit     (is_commit),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .iq            (iQ1),
        .q             (Q1),
        .v             (V1)
    );

    regfile_read_port u_read_port2 (
        .idx           (rs2),
        .values        (values),
        .busy          (busy),
        .tags          (tags),
        .is_commit     (is_commit),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .iq            (iQ2),
        .q             (Q2),
        .v             (V2)
    );

endmodule
